// File: rtl/weight_mem_ctrl.sv
// Weight memory sequencer: host programming in phase 0, arbitrated read / write-back in phase 1.
// All memory control outputs and requester handshakes are registered.
module weight_mem_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              phase_infer,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DW-1:0]     host_wdata,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DW-1:0]     rd_data,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DW-1:0]     wb_wdata,
  output logic              wb_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic              busy
);

  localparam int CW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WB_DO, RESP} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_last_wb;
  logic          w_grant_wb;
  logic          w_grant_rd;

  // On a tie, the port that did not win last time is served.
  always_comb begin
    w_grant_wb = wb_req && (!rd_req || !r_last_wb);
    w_grant_rd = rd_req && (!wb_req ||  r_last_wb);
  end

  assign busy = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_last_wb <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      wb_ack    <= 1'b0;
    end else if (!phase_infer) begin
      // Host owns the memory; any in-flight phase-1 operation is dropped.
      mem_we    <= host_we;
      mem_addr  <= host_addr;
      mem_wdata <= host_wdata;
      rd_valid  <= 1'b0;
      wb_ack    <= 1'b0;
      r_cnt     <= '0;
      r_state   <= IDLE;
    end else begin
      mem_we   <= 1'b0;
      rd_valid <= 1'b0;
      wb_ack   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_wb) begin
            mem_we    <= 1'b1;
            mem_addr  <= wb_addr;
            mem_wdata <= wb_wdata;
            r_last_wb <= 1'b1;
            r_state   <= WB_DO;
          end else if (w_grant_rd) begin
            mem_addr  <= rd_addr;
            r_cnt     <= CW'(RD_LAT);
            r_last_wb <= 1'b0;
            r_state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (r_cnt == '0) begin
            rd_data  <= mem_rdata;
            rd_valid <= 1'b1;
            r_state  <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        WB_DO: begin
          wb_ack  <= 1'b1;
          r_state <= RESP;
        end
        // One dead cycle lets the requester drop its request before re-arbitration.
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_mem_ctrl.sv
// Scoreboard bench for weight_mem_ctrl: stimulus pushes expected pulses (kind, data, cycle),
// a negedge monitor pops and compares whenever rd_valid or wb_ack appears.
module tb_weight_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       phase_infer;
  logic       host_we;
  logic [3:0] host_addr;
  logic [7:0] host_wdata;
  logic       rd_req;
  logic [3:0] rd_addr;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       wb_req;
  logic [3:0] wb_addr;
  logic [7:0] wb_wdata;
  logic       wb_ack;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;

  weight_mem_ctrl #(.ADDR_W(4), .DW(8), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .phase_infer(phase_infer),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_ack(wb_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory, one cycle of read latency.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    bit         is_wb;
    logic [7:0] data;
    int         at;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_wb, input logic [7:0] data, input int at);
    exp_t e;
    e.is_wb = is_wb;
    e.data  = data;
    e.at    = at;
    q.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n && (rd_valid || wb_ack)) begin
      if (q.size() == 0) begin
        chk(rd_valid ? "unexpected_rd_valid" : "unexpected_wb_ack", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind_is_wb", {31'd0, wb_ack}, {31'd0, e.is_wb});
        chk("pulse_cycle", cyc, e.at);
        if (!e.is_wb) chk("rd_data", {24'd0, rd_data}, {24'd0, e.data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request while the FSM is idle and hold it until its pulse is seen.
  task automatic req_op(input bit is_wb, input logic [3:0] addr, input logic [7:0] data,
                        input logic [7:0] exp_rd);
    int  t;
    bit  seen;
    t = cyc;
    seen = 0;
    if (is_wb) begin
      wb_req = 1; wb_addr = addr; wb_wdata = data;
      push(1, 8'h00, t + 2);
    end else begin
      rd_req = 1; rd_addr = addr;
      push(0, exp_rd, t + 3);
    end
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if ((is_wb && wb_ack) || (!is_wb && rd_valid)) seen = 1;
    end
    wb_req = 0;
    rd_req = 0;
    if (!seen) chk("req_op_timeout", 1, 0);
    tick();
  endtask

  initial begin
    int t;
    int r;
    rst_n = 0; phase_infer = 0;
    host_we = 0; host_addr = 0; host_wdata = 0;
    rd_req = 0; rd_addr = 0; wb_req = 0; wb_addr = 0; wb_wdata = 0;

    // Reset state
    tick();
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_mem_addr", {28'd0, mem_addr}, 0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 0);
    chk("rst_rd_data", {24'd0, rd_data}, 0);
    chk("rst_wb_ack", {31'd0, wb_ack}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst_n = 1;
    tick();

    // Host programming
    host_we = 1; host_addr = 4'd3; host_wdata = 8'hA5;
    tick();
    chk("host_mem_we", {31'd0, mem_we}, 1);
    chk("host_mem_addr", {28'd0, mem_addr}, 3);
    chk("host_mem_wdata", {24'd0, mem_wdata}, 8'hA5);
    host_we = 0;
    tick();
    chk("host_mem_we_off", {31'd0, mem_we}, 0);

    // Read with busy window
    phase_infer = 1;
    rd_req = 1; rd_addr = 4'd3;
    t = cyc;
    push(0, 8'hA5, t + 3);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("read_busy", {31'd0, busy}, (k <= 3) ? 1 : 0);
      if (k == 3) rd_req = 0;
      if (k == 4) chk("rd_data_held", {24'd0, rd_data}, 8'hA5);
    end

    // Write-back then read back
    wb_req = 1; wb_addr = 4'd7; wb_wdata = 8'h3C;
    t = cyc;
    push(1, 8'h00, t + 2);
    tick();
    chk("wb_mem_we_t1", {31'd0, mem_we}, 1);
    chk("wb_mem_addr", {28'd0, mem_addr}, 7);
    chk("wb_mem_wdata", {24'd0, mem_wdata}, 8'h3C);
    tick();
    chk("wb_mem_we_t2", {31'd0, mem_we}, 0);
    wb_req = 0;
    tick();
    req_op(0, 4'd7, 8'h00, 8'h3C);

    // Tie from reset: WB, RD, WB, RD
    rst_n = 0;
    wb_req = 1; wb_addr = 4'd5; wb_wdata = 8'h5A;
    rd_req = 1; rd_addr = 4'd5;
    tick();
    rst_n = 1;
    r = cyc;
    push(1, 8'h00, r + 2);
    push(0, 8'h5A, r + 6);
    push(1, 8'h00, r + 9);
    push(0, 8'h6B, r + 13);
    for (int k = 0; k < 40 && cyc < r + 13; k++) begin
      tick();
      if (cyc == r + 3) wb_wdata = 8'h6B;
    end
    wb_req = 0; rd_req = 0;
    tick();

    // Abort a read by leaving phase 1 during RD_WAIT
    rd_req = 1; rd_addr = 4'd3;
    tick();
    chk("abort_busy_rdwait", {31'd0, busy}, 1);
    phase_infer = 0; rd_req = 0;
    host_we = 1; host_addr = 4'd9; host_wdata = 8'h77;
    tick();
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_host_we", {31'd0, mem_we}, 1);
    chk("abort_host_addr", {28'd0, mem_addr}, 9);
    chk("abort_host_wdata", {24'd0, mem_wdata}, 8'h77);
    host_we = 0;
    repeat (4) tick();

    // Reset during WB_DO
    phase_infer = 1;
    wb_req = 1; wb_addr = 4'd2; wb_wdata = 8'hC3;
    tick();
    chk("midop_mem_we", {31'd0, mem_we}, 1);
    #2;
    rst_n = 0;
    #1;
    chk("midop_rst_mem_we", {31'd0, mem_we}, 0);
    chk("midop_rst_mem_addr", {28'd0, mem_addr}, 0);
    chk("midop_rst_mem_wdata", {24'd0, mem_wdata}, 0);
    chk("midop_rst_busy", {31'd0, busy}, 0);
    chk("midop_rst_rd_data", {24'd0, rd_data}, 0);
    chk("midop_rst_wb_ack", {31'd0, wb_ack}, 0);
    wb_req = 0;
    tick();
    tick();
    rst_n = 1;
    repeat (6) tick();

    chk("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
